// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, bf_mode encodings and FSM types for the NTT controller
package ntt_pkg;
    localparam int N              = 256;
    localparam int LAYERS         = 7;
    localparam int BFLY_PER_LAYER = N / 2;
    localparam int RD_LAT         = 1;
    localparam int BF_LAT         = 4;

    localparam logic [1:0] BF_NTT  = 2'b00;
    localparam logic [1:0] BF_INTT = 2'b01;
    localparam logic [1:0] BF_IDLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       en;
        logic [7:0] a;
        logic [7:0] b;
    } wb_ent_t;
endpackage

// File: rtl/ntt_ctrl_if.sv
// rtl/ntt_ctrl_if.sv - control, RAM read and write-back signals of the NTT controller
interface ntt_ctrl_if;
    logic       start;
    logic       inv;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [6:0] tw_addr;
    logic [1:0] bf_mode;
    logic       wr_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;

    modport master (
        input  start, inv,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_mode,
        output wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start, inv,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_mode,
        input  wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ntt_addr_gen.sv
// rtl/ntt_addr_gen.sv - combinational butterfly pair and twiddle index for layer s, butterfly i
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [2:0] s,
    input  logic [6:0] i,
    input  logic       inv,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] tw_addr
);
    logic [2:0] p;
    logic [7:0] len;
    logic [7:0] mask;
    logic [7:0] ii;
    logic [7:0] a;
    logic [6:0] g;

    // Inserting a zero at bit p splits i into group (high bits) and offset within the group.
    always_comb begin
        p         = inv ? (s + 3'd1) : (3'd7 - s);
        len       = 8'd1 << p;
        mask      = len - 8'd1;
        ii        = {1'b0, i};
        a         = ((ii & ~mask) << 1) | (ii & mask);
        g         = i >> p;
        rd_addr_a = a;
        rd_addr_b = a + len;
        if (inv) begin
            tw_addr = 7'((9'd256 >> p) - 9'd1 - {2'b00, g});
        end else begin
            tw_addr = 7'((8'd128 >> p) + {1'b0, g});
        end
    end
endmodule

// File: rtl/ntt_ctrl.sv
// rtl/ntt_ctrl.sv - layer/butterfly sequencer for a 256-point NTT/INTT with a write-back delay line
module ntt_ctrl #(
    parameter int RD_LAT = ntt_pkg::RD_LAT,
    parameter int BF_LAT = ntt_pkg::BF_LAT
) (
    input  logic clk,
    input  logic rst,
    ntt_ctrl_if.master bus
);
    import ntt_pkg::*;

    localparam int WB_DLY = RD_LAT + BF_LAT;
    localparam int DCW    = $clog2(WB_DLY + 1);

    state_t         state;
    state_t         state_nx;
    logic [2:0]     s_q;
    logic [6:0]     i_q;
    logic [DCW-1:0] d_q;
    logic           inv_q;
    logic [7:0]     gen_a;
    logic [7:0]     gen_b;
    logic [6:0]     gen_tw;
    logic [7:0]     hold_a;
    logic [7:0]     hold_b;
    logic [6:0]     hold_tw;
    logic           issue;
    logic           last_wr;
    logic           busy_i;
    wb_ent_t        dly [WB_DLY];

    ntt_addr_gen u_addr_gen (
        .s         (s_q),
        .i         (i_q),
        .inv       (inv_q),
        .rd_addr_a (gen_a),
        .rd_addr_b (gen_b),
        .tw_addr   (gen_tw)
    );

    assign issue   = (state == ST_ISSUE);
    // The last write of a layer always lands WB_DLY cycles after its last issue.
    assign last_wr = (state == ST_DRAIN) && (d_q == DCW'(WB_DLY - 1));
    assign busy_i  = issue || (state == ST_DRAIN);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nx = ST_ISSUE;
            ST_ISSUE: if (i_q == 7'(BFLY_PER_LAYER - 1)) state_nx = ST_DRAIN;
            ST_DRAIN: if (last_wr) state_nx = (s_q == 3'(LAYERS - 1)) ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            s_q     <= '0;
            i_q     <= '0;
            d_q     <= '0;
            inv_q   <= 1'b0;
            hold_a  <= '0;
            hold_b  <= '0;
            hold_tw <= '0;
            for (int k = 0; k < WB_DLY; k++) begin
                dly[k] <= '0;
            end
        end else begin
            state <= state_nx;
            if ((state == ST_IDLE) && bus.start) begin
                s_q   <= '0;
                i_q   <= '0;
                d_q   <= '0;
                inv_q <= bus.inv;
            end
            // i stops at 127 so the addresses hold through DRAIN without extra muxing.
            if (issue) begin
                hold_a  <= gen_a;
                hold_b  <= gen_b;
                hold_tw <= gen_tw;
                if (i_q != 7'(BFLY_PER_LAYER - 1)) begin
                    i_q <= i_q + 7'd1;
                end
            end
            if (state == ST_DRAIN) begin
                d_q <= last_wr ? '0 : d_q + 1'b1;
            end
            if (last_wr && (s_q != 3'(LAYERS - 1))) begin
                s_q <= s_q + 3'd1;
                i_q <= '0;
            end
            dly[0] <= '{en: issue, a: gen_a, b: gen_b};
            for (int k = 1; k < WB_DLY; k++) begin
                dly[k] <= dly[k-1];
            end
        end
    end

    assign bus.busy      = busy_i;
    assign bus.done      = (state == ST_DONE);
    assign bus.rd_en     = issue;
    assign bus.rd_addr_a = issue ? gen_a  : hold_a;
    assign bus.rd_addr_b = issue ? gen_b  : hold_b;
    assign bus.tw_addr   = issue ? gen_tw : hold_tw;
    assign bus.bf_mode   = busy_i ? (inv_q ? BF_INTT : BF_NTT) : BF_IDLE;
    assign bus.wr_en     = dly[WB_DLY-1].en;
    assign bus.wr_addr_a = dly[WB_DLY-1].a;
    assign bus.wr_addr_b = dly[WB_DLY-1].b;
endmodule

// File: tb/tb_ntt_ctrl.sv
// tb/tb_ntt_ctrl.sv - directed self-checking bench for ntt_ctrl with a cycle-timeline reference
module tb_ntt_ctrl;
    localparam int WB0 = 5;
    localparam int WB2 = 3;
    localparam int WB6 = 7;

    typedef struct {
        int         t;
        logic       inv;
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] tw;
    } dv_t;

    dv_t dvec [13] = '{
        '{1,   1'b0, 8'd0,   8'd128, 7'd1},
        '{2,   1'b0, 8'd1,   8'd129, 7'd1},
        '{128, 1'b0, 8'd127, 8'd255, 7'd1},
        '{134, 1'b0, 8'd0,   8'd64,  7'd2},
        '{135, 1'b0, 8'd1,   8'd65,  7'd2},
        '{1,   1'b1, 8'd0,   8'd2,   7'd127},
        '{2,   1'b1, 8'd1,   8'd3,   7'd127},
        '{3,   1'b1, 8'd4,   8'd6,   7'd126},
        '{127, 1'b1, 8'd252, 8'd254, 7'd64},
        '{128, 1'b1, 8'd253, 8'd255, 7'd64},
        '{799, 1'b1, 8'd0,   8'd128, 7'd1},
        '{850, 1'b1, 8'd51,  8'd179, 7'd1},
        '{926, 1'b1, 8'd127, 8'd255, 7'd1}
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_sw = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ntt_ctrl_if b0 ();
    ntt_ctrl_if b2 ();
    ntt_ctrl_if b6 ();

    ntt_ctrl dut (.clk(clk), .rst(rst), .bus(b0));
    ntt_ctrl #(.BF_LAT(2)) dut_bf2 (.clk(clk), .rst(rst_sw), .bus(b2));
    ntt_ctrl #(.BF_LAT(6)) dut_bf6 (.clk(clk), .rst(rst_sw), .bus(b6));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Clean-run timeline: which butterfly (if any) issues in cycle t.
    function automatic void exp_ent(input int t, input int wb, output logic en, output int s, output int i);
        int per;
        per = 128 + wb;
        en  = 1'b0;
        s   = 0;
        i   = 0;
        if (t >= 1) begin
            s  = (t - 1) / per;
            i  = (t - 1) % per;
            en = (s < 7) && (i < 128);
        end
    endfunction

    function automatic void exp_addr(input int s, input int i, input logic inv_v,
                                     output logic [7:0] a, output logic [7:0] b, output logic [6:0] tw);
        int len;
        int g;
        int j;
        len = inv_v ? (2 << s) : (128 >> s);
        g   = i / len;
        j   = 2 * len * g + (i % len);
        a   = 8'(j);
        b   = 8'(j + len);
        tw  = inv_v ? 7'(256 / len - 1 - g) : 7'(128 / len + g);
    endfunction

    task automatic chk_sw(input string nm, input int t, input int wb,
                          input logic rd, input logic wr, input logic bz, input logic dn);
        logic en;
        logic wen;
        int   s;
        int   i;
        int   per;
        per = 128 + wb;
        exp_ent(t, wb, en, s, i);
        exp_ent(t - wb, wb, wen, s, i);
        chk($sformatf("%s_rd_en@%0d", nm, t), rd, en);
        chk($sformatf("%s_wr_en@%0d", nm, t), wr, wen);
        chk($sformatf("%s_busy@%0d", nm, t), bz, (t >= 1) && (t <= 7 * per));
        chk($sformatf("%s_done@%0d", nm, t), dn, t == 7 * per + 1);
    endtask

    task automatic run(input logic inv_v, input int pulse_at, input int rst_at, input int ncyc, input bit sweep);
        logic       en;
        logic       wen;
        logic       busy_e;
        logic       gone;
        int         s;
        int         i;
        int         ws;
        int         wi;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [6:0] etw;
        logic [7:0] la;
        logic [7:0] lb;
        logic [6:0] ltw;
        bit [255:0] seen;
        la   = '0;
        lb   = '0;
        ltw  = '0;
        seen = '0;
        @(negedge clk);
        b0.start = 1'b1;
        b0.inv   = inv_v;
        if (sweep) begin
            b2.start = 1'b1;
            b6.start = 1'b1;
        end
        for (int t = 1; t <= ncyc; t++) begin
            @(negedge clk);
            b0.start = 1'b0;
            b0.inv   = ~inv_v;
            b2.start = 1'b0;
            b6.start = 1'b0;
            gone = (rst_at > 0) && (t > rst_at);
            if (gone) begin
                chk($sformatf("abort_rd_en@%0d", t), b0.rd_en, 1'b0);
                chk($sformatf("abort_wr_en@%0d", t), b0.wr_en, 1'b0);
                chk($sformatf("abort_busy@%0d", t), b0.busy, 1'b0);
                chk($sformatf("abort_done@%0d", t), b0.done, 1'b0);
                chk($sformatf("abort_bf_mode@%0d", t), b0.bf_mode, 2'b11);
                chk($sformatf("abort_addr@%0d", t), {b0.rd_addr_a, b0.rd_addr_b, b0.tw_addr}, 32'd0);
            end else begin
                exp_ent(t, WB0, en, s, i);
                busy_e = (t >= 1) && (t <= 7 * (128 + WB0));
                chk($sformatf("rd_en@%0d", t), b0.rd_en, en);
                chk($sformatf("busy@%0d", t), b0.busy, busy_e);
                chk($sformatf("done@%0d", t), b0.done, t == 7 * (128 + WB0) + 1);
                chk($sformatf("bf_mode@%0d", t), b0.bf_mode, busy_e ? {1'b0, inv_v} : 2'b11);
                if (en) begin
                    exp_addr(s, i, inv_v, la, lb, ltw);
                end
                chk($sformatf("rd_addr_a@%0d", t), b0.rd_addr_a, la);
                chk($sformatf("rd_addr_b@%0d", t), b0.rd_addr_b, lb);
                chk($sformatf("tw_addr@%0d", t), b0.tw_addr, ltw);
                exp_ent(t - WB0, WB0, wen, ws, wi);
                chk($sformatf("wr_en@%0d", t), b0.wr_en, wen);
                if (wen) begin
                    exp_addr(ws, wi, inv_v, ea, eb, etw);
                    chk($sformatf("wr_addr_a@%0d", t), b0.wr_addr_a, ea);
                    chk($sformatf("wr_addr_b@%0d", t), b0.wr_addr_b, eb);
                    seen[b0.wr_addr_a] = 1'b1;
                    seen[b0.wr_addr_b] = 1'b1;
                    if (wi == 127) begin
                        chk($sformatf("distinct_wr_layer%0d", ws), $countones(seen), 256);
                        seen = '0;
                    end
                end
                foreach (dvec[k]) begin
                    if ((dvec[k].t == t) && (dvec[k].inv == inv_v)) begin
                        chk($sformatf("dv_rd_a@%0d", t), b0.rd_addr_a, dvec[k].a);
                        chk($sformatf("dv_rd_b@%0d", t), b0.rd_addr_b, dvec[k].b);
                        chk($sformatf("dv_tw@%0d", t), b0.tw_addr, dvec[k].tw);
                    end
                end
            end
            if (sweep) begin
                chk_sw("bf2", t, WB2, b2.rd_en, b2.wr_en, b2.busy, b2.done);
                chk_sw("bf6", t, WB6, b6.rd_en, b6.wr_en, b6.busy, b6.done);
            end
            if (t == pulse_at) begin
                b0.start = 1'b1;
            end
            if (t == rst_at) begin
                rst = 1'b1;
            end
            if ((rst_at > 0) && (t == rst_at + 1)) begin
                rst = 1'b0;
            end
        end
        b0.inv = 1'b0;
    endtask

    initial begin
        b0.start = 1'b0;
        b0.inv   = 1'b0;
        b2.start = 1'b0;
        b2.inv   = 1'b0;
        b6.start = 1'b0;
        b6.inv   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", b0.busy, 1'b0);
        chk("rst_done", b0.done, 1'b0);
        chk("rst_rd_en", b0.rd_en, 1'b0);
        chk("rst_wr_en", b0.wr_en, 1'b0);
        chk("rst_rd_a", b0.rd_addr_a, 8'd0);
        chk("rst_rd_b", b0.rd_addr_b, 8'd0);
        chk("rst_tw", b0.tw_addr, 7'd0);
        chk("rst_wr_a", b0.wr_addr_a, 8'd0);
        chk("rst_wr_b", b0.wr_addr_b, 8'd0);
        chk("rst_bf_mode", b0.bf_mode, 2'b11);
        b0.start = 1'b1;
        rst_sw   = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        b0.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("start_in_rst_busy%0d", k), b0.busy, 1'b0);
            chk($sformatf("start_in_rst_rd_en%0d", k), b0.rd_en, 1'b0);
        end
        run(1'b0, 0, 0, 950, 1'b1);
        run(1'b1, 300, 0, 940, 1'b0);
        run(1'b0, 0, 500, 940, 1'b0);
        run(1'b0, 0, 0, 940, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
